// File: rtl/iterative_subtractor33_if.sv
// Operand/result handshake bundle for iterative_subtractor33.
// master: the producer/consumer side that drives operands, flush and out_ready.
// slave : the subtractor itself.
//   flush               synchronous abort request
//   in_valid/in_ready   operand handshake, A/B are the WIDTH-bit operands
//   out_valid/out_ready result handshake, Diff/Borrow/Zero are the result fields
interface iterative_subtractor33_if #(
  parameter int WIDTH = 33
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   Diff;
  logic             Borrow;
  logic             Zero;

  modport master (
    output flush, in_valid, A, B, out_ready,
    input  in_ready, out_valid, Diff, Borrow, Zero
  );

  modport slave (
    input  flush, in_valid, A, B, out_ready,
    output in_ready, out_valid, Diff, Borrow, Zero
  );
endinterface

// File: rtl/iterative_subtractor33.sv
// Multi-cycle unsigned subtractor: Diff = A - B, CHUNK bits per clock, LSB chunk
// first, with the borrow carried between cycles in a register. Trades latency
// (WIDTH/CHUNK cycles) for a CHUNK-bit critical path.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  iterative_subtractor33_if.slave (flush, operand and result handshakes)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready=1, waiting for operands
// BUSY  | one chunk per clock, cnt selects the chunk
// DONE  | out_valid=1, result held until out_ready
module iterative_subtractor33 #(
  parameter int WIDTH = 33,
  parameter int CHUNK = 3
) (
  input logic                    clk,
  input logic                    rst,
  iterative_subtractor33_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("iterative_subtractor33: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   diff_q;
  logic             zero_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   sub;
  logic [WIDTH-1:0] diff_low_next;
  logic             last_chunk;

  // Chunk selection uses constant slices compared against cnt so no
  // variable part-select is needed.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // One extra bit so the MSB is the borrow out of this chunk.
  assign sub = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};

  // Low result field with the current chunk merged in; Zero is taken from
  // this on the last chunk so it sees the final digit too.
  always_comb begin
    diff_low_next = diff_q[WIDTH-1:0];
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) diff_low_next[k*CHUNK +: CHUNK] = sub[CHUNK-1:0];
    end
  end

  assign last_chunk = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUSY;
      BUSY:    if (last_chunk)    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      zero_q   <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (bus.flush) begin
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        BUSY: begin
          diff_q[WIDTH-1:0] <= diff_low_next;
          borrow_q          <= sub[CHUNK];
          if (last_chunk) begin
            diff_q[WIDTH] <= sub[CHUNK];
            zero_q        <= (diff_low_next == '0);
            cnt_q         <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Diff      = diff_q;
  assign bus.Borrow    = diff_q[WIDTH];
  assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_iterative_subtractor33.sv
module tb_iterative_subtractor33;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [33:0] sb_q[$];

  iterative_subtractor33_if #(.WIDTH(33)) bus ();

  iterative_subtractor33 #(.WIDTH(33), .CHUNK(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops the oldest expected result on every completed handshake.
  always @(negedge clk) begin
    logic [33:0] exp;
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result Diff=%h with no pending operation", bus.Diff);
      end else begin
        exp = sb_q.pop_front();
        if (bus.Diff !== exp || bus.Borrow !== exp[33] || bus.Zero !== (exp[32:0] == 33'd0)) begin
          n_fail++;
          $display("FAIL result Diff=%h Borrow=%b Zero=%b expected Diff=%h Borrow=%b Zero=%b",
                   bus.Diff, bus.Borrow, bus.Zero, exp, exp[33], (exp[32:0] == 33'd0));
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check("wait_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check("wait_out_valid", 64'(bus.out_valid), 64'd1);
  endtask

  // Presents operands for exactly one accept edge; optionally records the
  // expected result.
  task automatic do_op(input logic [32:0] a, input logic [32:0] b,
                       input logic [33:0] exp, input bit push);
    wait_ready();
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    if (push) sb_q.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    wait_valid();
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat;
    bit seen;
    logic [32:0] ra, rb;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.out_ready = 1'b1;

    #3;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_diff", 64'(bus.Diff), 64'd0);
    check("reset_borrow_zero", {62'd0, bus.Borrow, bus.Zero}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: latency and basic value
    do_op(33'd5, 33'd3, 34'h0_0000_0002, 1'b1);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 64'(lat), 64'd11);
    @(posedge clk); #1;

    // 2, 3: borrow and zero boundaries
    do_op(33'd0, 33'd1, 34'h3_FFFF_FFFF, 1'b1);
    wait_done();
    do_op(33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 34'h0_0000_0000, 1'b1);
    wait_done();
    do_op(33'h1_0000_0000, 33'd1, 34'h0_FFFF_FFFF, 1'b1);
    wait_done();
    do_op(33'd0, 33'h1_FFFF_FFFF, 34'h2_0000_0001, 1'b1);
    wait_done();

    // 4: backpressure in DONE with new operands waiting
    bus.out_ready = 1'b0;
    do_op(33'd7, 33'd2, 34'h0_0000_0005, 1'b1);
    wait_valid();
    bus.A = 33'd100;
    bus.B = 33'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_diff", 64'(bus.Diff), 64'h5);
      check("hold_flags", {61'd0, bus.in_ready, bus.out_valid, bus.Zero}, 64'b010);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_idle", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
    sb_q.push_back(34'h0_0000_0063);
    @(posedge clk); #1;
    check("hold_accept_after", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    wait_done();

    // 5: async reset mid-operation
    do_op(33'd50, 33'd20, 34'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_diff", 64'(bus.Diff), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(33'd9, 33'd4, 34'h0_0000_0005, 1'b1);
    wait_done();

    // 6: flush during BUSY, then flush in DONE
    do_op(33'd40, 33'd1, 34'd0, 1'b0);
    repeat (6) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy_idle", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush_busy_no_valid", 64'(seen), 64'd0);
    bus.out_ready = 1'b0;
    do_op(33'd8, 33'd8, 34'd0, 1'b0);
    wait_valid();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_done_idle", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
    bus.out_ready = 1'b1;

    // Random operands against a wide reference subtraction
    for (int i = 0; i < 1000; i++) begin
      ra = {1'($urandom), 32'($urandom)};
      rb = {1'($urandom), 32'($urandom)};
      if (i % 50 == 0) rb = ra;
      do_op(ra, rb, {1'b0, ra} - {1'b0, rb}, 1'b1);
      wait_done();
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
